in12_scan_driver: RTL and testbench
===================================

IN12_SCAN_DRIVER -- requirements
Module: in12_scan_driver

Interface
REQ-001 Parameters SHALL be: DIGITS, default 8, number of IN-12 tubes scanned; STROBE_CYCLES, default 4, strobe high time in Clk cycles; DWELL_CYCLES, default 50000, per-digit on-time (1 ms at 50 MHz).
REQ-002 Clk  in  1  50 MHz system clock; the only clock.
REQ-003 Rst_n  in  1  reset, synchronous and active-low.
REQ-004 digit_we  in  1  digit buffer write strobe.
REQ-005 digit_addr  in  3  digit index; writes with digit_addr >= DIGITS are ignored.
REQ-006 digit_data  in  4  BCD code; 10..15 = blank.
REQ-007 enable  in  1  scan enable.
REQ-008 bus_req  out  1  request for the shared emulData bus.
REQ-009 bus_gnt  in  1  bus grant from the arbiter.
REQ-010 data  out  8  bus value, merged onto emulData by the arbiter.
REQ-011 in12_clear, in12_write_anode, in12_write_cathode  out  1 each  latch strobes.
REQ-012 frame_done  out  1  one-cycle pulse after the last digit's dwell.

Function
REQ-013 Buffer: DIGITS x 4-bit registers; the write takes effect on the Clk edge where digit_we=1.
REQ-014 FSM states: IDLE, REQ, CLR, ANODE, CATH, REL, DWELL, OFF_REQ, OFF_CLR.
REQ-015 IDLE: when enable=1, go to REQ.
REQ-016 REQ: bus_req=1; on bus_gnt=1, go to CLR.
REQ-017 bus_req: 1 in REQ, CLR, ANODE, CATH, OFF_REQ, OFF_CLR; 0 elsewhere.
REQ-018 Write phase (CLR, ANODE, CATH, OFF_CLR): 1 setup cycle, then STROBE_CYCLES with the strobe high, then 1 hold cycle (STROBE_CYCLES+2 cycles total); data is constant for the whole phase.
REQ-019 Phase data and strobe:
  - CLR/OFF_CLR: data=0x00, strobe in12_clear.
  - ANODE: data=8'b1<<idx, strobe in12_write_anode.
  - CATH: data={4'h0, code}, strobe in12_write_cathode.
REQ-020 code SHALL be latched from buffer[idx] on the ANODE->CATH transition; a same-edge write to that entry is not seen until the next visit.
REQ-021 data SHALL be 0x00 whenever the block is not in a write phase.
REQ-022 Phase order: CATH -> REL (1 cycle, bus released) -> DWELL.
REQ-023 DWELL: count DWELL_CYCLES cycles, then advance idx, wrapping DIGITS-1 -> 0.
REQ-024 frame_done SHALL pulse on the cycle the idx wrap occurs.
REQ-025 After DWELL: enable=1 -> REQ; enable=0 -> OFF_REQ.
REQ-026 OFF_REQ waits for bus_gnt, then enters OFF_CLR; OFF_CLR exits to IDLE, so tubes are always left dark.
REQ-027 Grant loss: if bus_gnt falls in CLR, ANODE or CATH, all strobes SHALL drop that cycle and the FSM SHALL return to REQ; the same idx restarts at CLR.
REQ-028 Grant loss in OFF_CLR SHALL return the FSM to OFF_REQ.
REQ-029 enable changes outside DWELL are ignored until the DWELL exit decision.

Reset
REQ-030 While Rst_n=0 at a Clk edge: state=IDLE, idx=0, buffer entries=4'hF, and all outputs (bus_req, data, all strobes, frame_done) = 0.
REQ-031 Reset asserted in any state, including mid-strobe, SHALL take effect at the next edge with no completion of the in-flight phase.

Structure
REQ-032 Package in12_pkg SHALL hold the state enum, the BLANK_CODE=4'hF constant, and the digit/code width constants.
REQ-033 The digit buffer SHALL be a sub-module, in12_digit_buf (write port + combinational read port).

Verification (DIGITS=8, STROBE_CYCLES=4, DWELL_CYCLES=20)
REQ-034 Reset, then enable=1, bus_gnt tied 1 -> sequence:
  - in12_clear high 4 cycles with data=0x00;
  - in12_write_anode high 4 cycles with data=0x01;
  - in12_write_cathode high 4 cycles with data=0x0F;
  - first cathode strobe rising edge exactly 16 cycles after enable.
REQ-035 Write buffer[3]=5, enable=1, bus_gnt=1 -> fourth anode phase has data=0x08 and its cathode phase has data=0x05; frame_done pulses once per 8 digits, every 8x(3x6+1+20+1)=320 cycles.
REQ-036 bus_gnt held 0 for 10 cycles after bus_req rises -> no strobes and data=0x00 throughout; CLR begins the cycle after bus_gnt=1.
REQ-037 bus_gnt dropped on the 2nd anode strobe cycle -> strobe low the same cycle, FSM in REQ; after regrant, CLR and ANODE repeat with the same idx.
REQ-038 enable=0 during DWELL of digit 5 -> one further in12_clear phase, then IDLE with bus_req=0; Rst_n=0 mid-CATH -> all outputs 0 at the next edge.

Source files
------------

// File: rtl/in12_pkg.sv
// Shared types and constants for the IN-12 nixie scan driver.
// States, code widths and the blank code used by buffer and FSM.
package in12_pkg;

  localparam int CODE_W = 4;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;

  localparam logic [CODE_W-1:0] BLANK_CODE = 4'hF;

  typedef enum logic [3:0] {
    IDLE,
    REQ,
    CLR,
    ANODE,
    CATH,
    REL,
    DWELL,
    OFF_REQ,
    OFF_CLR
  } state_t;

endpackage

// File: rtl/in12_digit_buf.sv
// Per-tube BCD code store: one synchronous write port,
// one combinational read port, blank after reset.
module in12_digit_buf
  import in12_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [CODE_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [CODE_W-1:0] rdata
);

  logic [CODE_W-1:0] mem [DIGITS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++)
        mem[i] <= BLANK_CODE;
    end else if (we && int'(waddr) < DIGITS) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = BLANK_CODE;
    if (int'(raddr) < DIGITS)
      rdata = mem[raddr];
  end

endmodule

// File: rtl/in12_scan_driver.sv
// Multiplexed IN-12 scan driver: per digit it clears, writes anode
// and cathode latches over the shared bus, then dwells.
module in12_scan_driver
  import in12_pkg::*;
#(
  parameter int DIGITS        = 8,
  parameter int STROBE_CYCLES = 4,
  parameter int DWELL_CYCLES  = 50000
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              digit_we,
  input  logic [ADDR_W-1:0] digit_addr,
  input  logic [CODE_W-1:0] digit_data,
  input  logic              enable,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [DATA_W-1:0] data,
  output logic              in12_clear,
  output logic              in12_write_anode,
  output logic              in12_write_cathode,
  output logic              frame_done
);

  localparam int PH_LEN  = STROBE_CYCLES + 2;
  localparam int CNT_MAX =
    (DWELL_CYCLES > PH_LEN) ? DWELL_CYCLES : PH_LEN;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(PH_LEN - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STROBE_CYCLES);
  localparam logic [CNT_W-1:0] DW_LAST  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DIGITS - 1);

  state_t            state;
  state_t            state_n;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] idx;
  logic [CODE_W-1:0] code;
  logic [CODE_W-1:0] buf_code;
  logic              run;
  logic              phase_end;
  logic              dwell_end;
  logic              strobe_on;

  in12_digit_buf #(
    .DIGITS (DIGITS)
  ) u_buf (
    .clk   (Clk),
    .rst_n (Rst_n),
    .we    (digit_we),
    .waddr (digit_addr),
    .wdata (digit_data),
    .raddr (idx),
    .rdata (buf_code)
  );

  assign phase_end = (cnt == PH_LAST);
  assign dwell_end = (state == DWELL) && (cnt == DW_LAST);
  assign strobe_on = (cnt != '0) && (cnt <= STB_LAST) && bus_gnt;

  // enable is registered so it only steers the FSM at its decision points
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      code  <= BLANK_CODE;
      run   <= 1'b0;
    end else begin
      state <= state_n;
      run   <= enable;
      cnt   <= (state_n != state) ? '0 : cnt + 1'b1;
      if (dwell_end)
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      if (state == ANODE && state_n == CATH)
        code <= buf_code;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (run) state_n = REQ;
      REQ:     if (bus_gnt) state_n = CLR;
      CLR: begin
        if (!bus_gnt)      state_n = REQ;
        else if (phase_end) state_n = ANODE;
      end
      ANODE: begin
        if (!bus_gnt)      state_n = REQ;
        else if (phase_end) state_n = CATH;
      end
      CATH: begin
        if (!bus_gnt)      state_n = REQ;
        else if (phase_end) state_n = REL;
      end
      REL:     state_n = DWELL;
      DWELL:   if (cnt == DW_LAST) state_n = run ? REQ : OFF_REQ;
      OFF_REQ: if (bus_gnt) state_n = OFF_CLR;
      OFF_CLR: begin
        if (!bus_gnt)      state_n = OFF_REQ;
        else if (phase_end) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus_req            = 1'b0;
    data               = '0;
    in12_clear         = 1'b0;
    in12_write_anode   = 1'b0;
    in12_write_cathode = 1'b0;
    frame_done         = dwell_end && (idx == IDX_LAST);
    unique case (state)
      REQ, OFF_REQ: bus_req = 1'b1;
      CLR, OFF_CLR: begin
        bus_req    = 1'b1;
        in12_clear = strobe_on;
      end
      ANODE: begin
        bus_req          = 1'b1;
        data             = DATA_W'(1) << idx;
        in12_write_anode = strobe_on;
      end
      CATH: begin
        bus_req            = 1'b1;
        data               = {4'h0, code};
        in12_write_cathode = strobe_on;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_in12_scan_driver.sv
// Directed bench for in12_scan_driver with short dwell.
// Cycle counts are relative to the negedge where enable is driven.
module tb_in12_scan_driver;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       digit_we;
  logic [2:0] digit_addr;
  logic [3:0] digit_data;
  logic       enable;
  logic       bus_gnt;
  logic       bus_req;
  logic [7:0] data;
  logic       in12_clear;
  logic       in12_write_anode;
  logic       in12_write_cathode;
  logic       frame_done;

  int vec  = 0;
  int miss = 0;
  int cyc  = 0;
  int t0   = 0;

  in12_scan_driver #(
    .DIGITS        (8),
    .STROBE_CYCLES (4),
    .DWELL_CYCLES  (20)
  ) dut (
    .Clk                (Clk),
    .Rst_n              (Rst_n),
    .digit_we           (digit_we),
    .digit_addr         (digit_addr),
    .digit_data         (digit_data),
    .enable             (enable),
    .bus_req            (bus_req),
    .bus_gnt            (bus_gnt),
    .data               (data),
    .in12_clear         (in12_clear),
    .in12_write_anode   (in12_write_anode),
    .in12_write_cathode (in12_write_cathode),
    .frame_done         (frame_done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    cyc++;
  endtask

  task automatic wait_to(input int rel);
    while (cyc - t0 < rel) tick();
  endtask

  task automatic do_reset();
    Rst_n    = 1'b0;
    enable   = 1'b0;
    bus_gnt  = 1'b0;
    digit_we = 1'b0;
    tick();
    tick();
    Rst_n = 1'b1;
  endtask

  function automatic logic [11:0] outs();
    return {bus_req, data, in12_clear,
            in12_write_anode, in12_write_cathode, frame_done};
  endfunction

  logic [7:0] adata [32];
  logic [7:0] cdata [32];

  initial begin
    int clr0, an0, ca0, first_ca, an_i, ca_i;
    int fd_n, fd1, fd2, bad, n_an, n_clr, first_idle;
    logic an_p, ca_p, rel_req;
    logic [7:0] rel_data, last_an;

    digit_addr = '0;
    digit_data = '0;
    tick();
    do_reset();
    Rst_n = 1'b0;
    tick();
    chk("rst_outs", 32'(outs()), 32'h0);
    chk("rst_req", 32'(bus_req), 32'h0);
    Rst_n = 1'b1;

    // buffer[3]=5 then free-running scan with grant tied high
    digit_we   = 1'b1;
    digit_addr = 3'd3;
    digit_data = 4'd5;
    tick();
    digit_we = 1'b0;
    tick();
    chk("idle_outs", 32'(outs()), 32'h0);
    bus_gnt = 1'b1;
    enable  = 1'b1;
    t0      = cyc;
    for (int k = 0; k < 32; k++) begin
      adata[k] = '0;
      cdata[k] = '0;
    end
    clr0 = 0; an0 = 0; ca0 = 0; first_ca = -1;
    an_i = -1; ca_i = -1; fd_n = 0; fd1 = -1; fd2 = -1;
    bad = 0; an_p = 0; ca_p = 0;
    rel_req = 1'b1; rel_data = 8'hFF;
    for (int i = 1; i <= 700; i++) begin
      tick();
      if (in12_clear) begin
        if (i <= 24) clr0++;
        if (data !== 8'h00) bad++;
      end
      if (in12_write_anode) begin
        if (i <= 24) an0++;
        if (!an_p) an_i++;
        if (an_i >= 0 && an_i < 32) adata[an_i] = data;
      end
      if (in12_write_cathode) begin
        if (i <= 24) ca0++;
        if (first_ca < 0) first_ca = i;
        if (!ca_p) ca_i++;
        if (ca_i >= 0 && ca_i < 32) cdata[ca_i] = data;
      end
      an_p = in12_write_anode;
      ca_p = in12_write_cathode;
      if (frame_done) begin
        fd_n++;
        if (fd_n == 1) fd1 = i;
        else if (fd_n == 2) fd2 = i;
      end
      if (i == 21) begin
        rel_req  = bus_req;
        rel_data = data;
      end
    end
    chk("first_cath_at", 32'(first_ca), 32'd16);
    chk("clr_len", 32'(clr0), 32'd4);
    chk("an_len", 32'(an0), 32'd4);
    chk("cath_len", 32'(ca0), 32'd4);
    chk("clr_data", 32'(bad), 32'd0);
    chk("an0_data", 32'(adata[0]), 32'h01);
    chk("cath0_data", 32'(cdata[0]), 32'h0F);
    chk("an3_data", 32'(adata[3]), 32'h08);
    chk("cath3_data", 32'(cdata[3]), 32'h05);
    chk("an7_data", 32'(adata[7]), 32'h80);
    chk("an8_wrap", 32'(adata[8]), 32'h01);
    chk("cath11_data", 32'(cdata[11]), 32'h05);
    chk("rel_req", 32'(rel_req), 32'h0);
    chk("rel_data", 32'(rel_data), 32'h0);
    chk("fd_count", 32'(fd_n), 32'd2);
    chk("fd_first", 32'(fd1), 32'd321);
    chk("fd_period", 32'(fd2 - fd1), 32'd320);

    // grant withheld for 10 cycles after the request
    do_reset();
    enable = 1'b1;
    t0     = cyc;
    wait_to(1);
    chk("req_pre", 32'(bus_req), 32'h0);
    bad = 0;
    for (int i = 2; i <= 11; i++) begin
      wait_to(i);
      if (bus_req !== 1'b1 || data !== 8'h00 ||
          in12_clear || in12_write_anode ||
          in12_write_cathode)
        bad++;
    end
    chk("nogrant_hold", 32'(bad), 32'd0);
    bus_gnt = 1'b1;
    wait_to(12);
    chk("clr_setup", 32'(in12_clear), 32'h0);
    wait_to(13);
    chk("clr_after_gnt", 32'(in12_clear), 32'h1);

    // grant lost on the 2nd anode strobe cycle
    wait_to(20);
    chk("an_2nd", 32'({in12_write_anode, data}), 32'h101);
    bus_gnt = 1'b0;
    #1;
    chk("an_drop", 32'(in12_write_anode), 32'h0);
    wait_to(21);
    chk("back_req", 32'({bus_req, data, in12_write_anode}),
        32'h200);
    bus_gnt = 1'b1;
    wait_to(23);
    chk("clr_redo", 32'(in12_clear), 32'h1);
    wait_to(29);
    chk("an_redo", 32'({in12_write_anode, data}), 32'h101);

    // disable during digit 5 dwell: one off-clear then idle
    n_an = 0; n_clr = 0; first_idle = -1;
    an_p = 1'b1; last_an = '0;
    for (int i = 30; i <= 300; i++) begin
      wait_to(i);
      if (in12_write_anode && !an_p) n_an++;
      if (in12_write_anode) last_an = data;
      an_p = in12_write_anode;
      if (i >= 261 && in12_clear) n_clr++;
      if (i >= 261 && !bus_req && first_idle < 0)
        first_idle = i;
      if (i == 250) enable = 1'b0;
    end
    chk("digits_before_off", 32'(n_an), 32'd5);
    chk("an5_data", 32'(last_an), 32'h20);
    chk("off_clr_len", 32'(n_clr), 32'd4);
    chk("idle_at", 32'(first_idle), 32'd268);
    chk("idle_outs2", 32'(outs()), 32'h0);

    // reset in the middle of a cathode strobe
    do_reset();
    bus_gnt = 1'b1;
    enable  = 1'b1;
    t0      = cyc;
    wait_to(17);
    chk("cath_mid", 32'(in12_write_cathode), 32'h1);
    Rst_n = 1'b0;
    wait_to(18);
    chk("rst_mid_cath", 32'(outs()), 32'h0);
    Rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, miss);
    $finish;
  end

endmodule
